// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame-level constants
// used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Bits on the wire per frame: start + data + stop.
    function automatic int frame_bits(input int bits_per_word);
        return bits_per_word + 2;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: synchronizes rx, centre-samples each frame and assembles
// NUM_WORDS frames into one output word with a single-cycle strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = 16,
    parameter int W_OUT            = 16,
    parameter int BITS_PER_WORD    = 8,
    localparam int NUM_WORDS       = W_OUT / BITS_PER_WORD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic             m_valid,
    output logic [W_OUT-1:0] m_data
);

    localparam int CNT_W = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int BIT_W = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BITS_PER_WORD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_WORDS - 1);

    uart_state_t                              state;
    logic                                     rx_p0;
    logic                                     rx_p1;
    logic                                     rearm_wait;
    logic [CNT_W-1:0]                         clk_cnt;
    logic [BIT_W-1:0]                         bit_cnt;
    logic [IDX_W-1:0]                         word_idx;
    logic [BITS_PER_WORD-1:0]                 shreg;
    logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]  slots;
    logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]  assembled;
    logic                                     bit_end;

    assign bit_end = (clk_cnt == CNT_LAST);

    // Word as it will look once the frame currently in shreg is accepted.
    always_comb begin
        assembled           = slots;
        assembled[word_idx] = shreg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rx_p0      <= STOP_BIT;
            rx_p1      <= STOP_BIT;
            rearm_wait <= 1'b0;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            word_idx   <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
        end else begin
            rx_p0   <= rx;
            rx_p1   <= rx_p0;
            m_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // After a framing error the line must go high before a
                    // new start edge is believed.
                    if (rearm_wait) begin
                        if (rx_p1 == STOP_BIT) rearm_wait <= 1'b0;
                    end else if (rx_p1 == START_BIT) begin
                        clk_cnt <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= (rx_p1 == START_BIT) ? DATA : IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                        if (rx_p1 == STOP_BIT) begin
                            if (word_idx == IDX_LAST) begin
                                m_data   <= assembled;
                                m_valid  <= 1'b1;
                                word_idx <= '0;
                            end else begin
                                word_idx <= word_idx + 1'b1;
                            end
                        end else begin
                            word_idx   <= '0;
                            rearm_wait <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == DATA && bit_end)
            shreg <= {rx_p1, shreg[BITS_PER_WORD-1:1]};
        if (state == STOP && bit_end && rx_p1 == STOP_BIT)
            slots[word_idx] <= shreg;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: latches a multi-word payload and sends it as back-to-back
// frames, word 0 first, each LSB first.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = 16,
    parameter int W_OUT            = 16,
    parameter int BITS_PER_WORD    = 8,
    localparam int NUM_WORDS       = W_OUT / BITS_PER_WORD
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     s_valid,
    input  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]  s_data,
    output logic                                     tx
);

    localparam int CNT_W = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int BIT_W = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_WORD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

    uart_state_t                              state;
    logic [CNT_W-1:0]                         clk_cnt;
    logic [BIT_W-1:0]                         bit_cnt;
    logic [IDX_W-1:0]                         word_idx;
    logic [IDX_W-1:0]                         idx_next;
    logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]  payload;
    logic [BITS_PER_WORD-1:0]                 shreg;
    logic                                     bit_end;

    assign bit_end  = (clk_cnt == CNT_LAST);
    assign idx_next = word_idx + 1'b1;

    // tx is registered from the current state, so every bit level appears one
    // edge after the state that owns it and lasts exactly one bit period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= STOP_BIT;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            word_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= STOP_BIT;
                    if (s_valid) begin
                        state    <= START;
                        clk_cnt  <= '0;
                        bit_cnt  <= '0;
                        word_idx <= '0;
                    end
                end
                START: begin
                    tx <= START_BIT;
                    if (bit_end) begin
                        clk_cnt <= '0;
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    tx <= shreg[0];
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx <= STOP_BIT;
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (word_idx == IDX_LAST) begin
                            word_idx <= '0;
                            state    <= IDLE;
                        end else begin
                            word_idx <= idx_next;
                            state    <= START;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Payload only loads from IDLE, so requests while busy leave it untouched.
    always_ff @(posedge clk) begin
        if (state == IDLE && s_valid) begin
            payload <= s_data;
            shreg   <= s_data[0];
        end else if (state == DATA && bit_end) begin
            shreg <= shreg >> 1;
        end else if (state == STOP && bit_end && word_idx != IDX_LAST) begin
            shreg <= payload[idx_next];
        end
    end

endmodule

// File: rtl/uart_main.sv
// UART transceiver top: independent transmit and receive paths on one clock.
module uart_main
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = 16,
    parameter int W_OUT            = 16,
    parameter int BITS_PER_WORD    = 8,
    localparam int NUM_WORDS       = W_OUT / BITS_PER_WORD
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic                                     rx,
    input  logic                                     s_valid,
    input  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]  s_data,
    output logic                                     tx,
    output logic                                     m_valid,
    output logic [W_OUT-1:0]                         m_data
);

    // rstn is active-high despite its name.
    uart_tx #(
        .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE),
        .W_OUT            (W_OUT),
        .BITS_PER_WORD    (BITS_PER_WORD)
    ) u_tx (
        .clk     (clk),
        .rst     (rstn),
        .s_valid (s_valid),
        .s_data  (s_data),
        .tx      (tx)
    );

    uart_rx #(
        .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE),
        .W_OUT            (W_OUT),
        .BITS_PER_WORD    (BITS_PER_WORD)
    ) u_rx (
        .clk     (clk),
        .rst     (rstn),
        .rx      (rx),
        .m_valid (m_valid),
        .m_data  (m_data)
    );

endmodule

// File: tb/tb_uart_main.sv
// Directed loopback bench for uart_main with hand-computed expectations.
module tb_uart_main;

    logic            clk = 1'b0;
    logic            rstn;
    logic            rx;
    logic            s_valid;
    logic [1:0][7:0] s_data;
    logic            tx;
    logic            m_valid;
    logic [15:0]     m_data;

    logic manual;
    logic rx_man;

    int n_checks = 0;
    int n_errors = 0;
    int mv_total = 0;

    always #5 clk = ~clk;

    assign rx = manual ? rx_man : tx;

    uart_main #(
        .CLOCKS_PER_PULSE (16),
        .W_OUT            (16),
        .BITS_PER_WORD    (8)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .rx      (rx),
        .s_valid (s_valid),
        .s_data  (s_data),
        .tx      (tx),
        .m_valid (m_valid),
        .m_data  (m_data)
    );

    always @(negedge clk) if (m_valid) mv_total <= mv_total + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        @(negedge clk);
        s_data  = w;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_mvalid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (m_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drive_bit(input logic b);
        rx_man = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int k = 0; k < 8; k++) drive_bit(d[k]);
        drive_bit(stop);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          base;
        int          lat;
        logic [9:0]  fr0;
        logic [9:0]  fr1;

        manual  = 1'b0;
        rx_man  = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        rstn    = 1'b1;
        fr0     = '0;
        fr1     = '0;
        lat     = -1;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_mvalid", m_valid, 0);
        check("rst_mdata", m_data, 16'h0000);
        rstn = 1'b0;
        repeat (5) @(negedge clk);

        // Single word with a busy-time request; j counts negedges after the sampling edge
        base = mv_total;
        @(negedge clk);
        s_data  = 16'hA55A;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        for (int j = 1; j <= 330; j++) begin
            @(negedge clk);
            if (j == 40) begin
                s_data  = 16'h1234;
                s_valid = 1'b1;
            end
            if (j == 41) s_valid = 1'b0;
            if (j >= 9 && (j - 9) % 16 == 0 && (j - 9) / 16 < 20) begin
                if ((j - 9) / 16 < 10) fr0[(j - 9) / 16] = tx;
                else                   fr1[(j - 9) / 16 - 10] = tx;
            end
            if (m_valid && lat < 0) lat = j;
        end
        check("frame0", fr0, {1'b1, 8'h5A, 1'b0});
        check("frame1", fr1, {1'b1, 8'hA5, 1'b0});
        check("single_count", mv_total - base, 1);
        check("single_data", m_data, 16'hA55A);
        check("single_latency", (lat >= 314 && lat <= 318), 1);
        check("single_tx_idle", tx, 1);

        // Back-to-back words
        base = mv_total;
        send_word(16'hFFFF);
        wait_mvalid(400, ok);
        check("b2b0_timeout", ok, 1);
        check("b2b0_data", m_data, 16'hFFFF);
        repeat (20) @(negedge clk);
        check("b2b0_hold", m_data, 16'hFFFF);
        send_word(16'h0000);
        wait_mvalid(400, ok);
        check("b2b1_timeout", ok, 1);
        check("b2b1_data", m_data, 16'h0000);
        repeat (20) @(negedge clk);
        check("b2b_count", mv_total - base, 2);

        // Framing error after one good frame, then a line break
        manual = 1'b1;
        rx_man = 1'b1;
        repeat (20) @(negedge clk);
        base = mv_total;
        drive_frame(8'h77, 1'b1);
        drive_frame(8'h55, 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_frame(8'h34, 1'b1);
        drive_frame(8'h12, 1'b1);
        repeat (20) @(negedge clk);
        check("ferr_count", mv_total - base, 1);
        check("ferr_data", m_data, 16'h1234);

        // Reset during the second frame's start bit
        manual = 1'b0;
        repeat (5) @(negedge clk);
        send_word(16'hBEEF);
        repeat (165) @(negedge clk);
        check("mid_tx_low", tx, 0);
        base = mv_total;
        #2 rstn = 1'b1;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_mvalid", m_valid, 0);
        check("mid_rst_mdata", m_data, 16'h0000);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        repeat (400) @(negedge clk);
        check("mid_no_mvalid", mv_total - base, 0);
        check("mid_tx_idle", tx, 1);
        send_word(16'hC3A5);
        wait_mvalid(400, ok);
        check("post_rst_timeout", ok, 1);
        check("post_rst_data", m_data, 16'hC3A5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
